// File: rtl/tlb_mmu_pkg.sv
// Shared bus and TLB types for the address translation unit, plus segment decode.
package tlb_mmu_pkg;

  localparam logic [3:0] KSEG0_A = 4'h8;
  localparam logic [3:0] KSEG0_B = 4'h9;
  localparam logic [3:0] KSEG1_A = 4'ha;
  localparam logic [3:0] KSEG1_B = 4'hb;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [1:0]  size;
    logic [31:0] wdata;
  } dbus_req_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_half_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_half_t   p0;
    tlb_half_t   p1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    SEG_KSEG0,
    SEG_KSEG1,
    SEG_MAPPED
  } seg_t;

  function automatic seg_t seg_of(input logic [31:0] addr);
    case (addr[31:28])
      KSEG0_A, KSEG0_B: seg_of = SEG_KSEG0;
      KSEG1_A, KSEG1_B: seg_of = SEG_KSEG1;
      default:          seg_of = SEG_MAPPED;
    endcase
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully associative TLB compare; purely combinational, lowest matching index wins.
module tlb_match
  import tlb_mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  localparam int IDX_W = $clog2(TLB_ENTRIES)
) (
  input  tlb_entry_t       entries [TLB_ENTRIES],
  input  logic [18:0]      vpn2,
  input  logic [7:0]       asid,
  input  logic             odd,
  output logic             hit,
  output logic [IDX_W-1:0] index,
  output tlb_half_t        half
);

  // Walk from the top down so the last assignment is the lowest matching index.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    half  = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].vpn2 == vpn2 && (entries[i].g || entries[i].asid == asid)) begin
        hit   = 1'b1;
        index = IDX_W'(i);
        half  = odd ? entries[i].p1 : entries[i].p0;
      end
    end
  end

endmodule

// File: rtl/tlb_mmu.sv
// Virtual-to-physical translation for ibus/dbus with a software-managed TLB.
// Translation is combinational (no added latency, no backpressure); probe/read results register one cycle later.
module tlb_mmu
  import tlb_mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter bit USE_TLB     = 1'b1,
  localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  ibus_req_t        ireq,
  input  dbus_req_t        dreq,
  output ibus_req_t        t_ireq,
  output dbus_req_t        t_dreq,
  output logic             i_uncached,
  output logic             d_uncached,
  input  logic [7:0]       asid,
  input  logic             k0_uncached,
  output logic             i_refill,
  output logic             d_refill,
  output logic             i_invalid,
  output logic             d_invalid,
  output logic             d_modified,
  input  logic             tlb_we,
  input  logic             tlb_wr_random,
  input  logic [IDX_W-1:0] tlb_windex,
  input  tlb_entry_t       tlb_wentry,
  input  logic [IDX_W-1:0] tlb_rindex,
  output tlb_entry_t       tlb_rentry,
  input  logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] random,
  input  logic             probe_req,
  input  logic [18:0]      probe_vpn2,
  input  logic [7:0]       probe_asid,
  output logic             probe_done,
  output logic             probe_hit,
  output logic [IDX_W-1:0] probe_index
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(TLB_ENTRIES - 1);

  tlb_entry_t       entries [TLB_ENTRIES];
  logic [IDX_W-1:0] random_next;
  logic [IDX_W:0]   wired_p1;

  logic             i_hit, d_hit, p_hit;
  logic [IDX_W-1:0] i_idx_unused, d_idx_unused, p_idx;
  tlb_half_t        i_half, d_half, p_half_unused;
  logic             i_dirty_unused;

  assign i_dirty_unused = i_half.d;

  tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_imatch (
    .entries(entries), .vpn2(ireq.addr[31:13]), .asid(asid), .odd(ireq.addr[12]),
    .hit(i_hit), .index(i_idx_unused), .half(i_half)
  );

  tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_dmatch (
    .entries(entries), .vpn2(dreq.addr[31:13]), .asid(asid), .odd(dreq.addr[12]),
    .hit(d_hit), .index(d_idx_unused), .half(d_half)
  );

  tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_pmatch (
    .entries(entries), .vpn2(probe_vpn2), .asid(probe_asid), .odd(1'b0),
    .hit(p_hit), .index(p_idx), .half(p_half_unused)
  );

  always_comb begin
    t_ireq     = ireq;
    i_uncached = 1'b0;
    i_refill   = 1'b0;
    i_invalid  = 1'b0;
    case (seg_of(ireq.addr))
      SEG_KSEG0: begin
        t_ireq.addr = {1'b0, ireq.addr[30:0]};
        i_uncached  = k0_uncached;
      end
      SEG_KSEG1: begin
        t_ireq.addr = {3'b000, ireq.addr[28:0]};
        i_uncached  = 1'b1;
      end
      default: begin
        if (USE_TLB) begin
          if (i_hit) begin
            t_ireq.addr = {i_half.pfn, ireq.addr[11:0]};
            i_uncached  = (i_half.c == 3'd2);
          end
          i_refill  = ireq.valid & ~i_hit;
          i_invalid = ireq.valid & i_hit & ~i_half.v;
        end
      end
    endcase
    if (i_refill || i_invalid) t_ireq.valid = 1'b0;
  end

  always_comb begin
    t_dreq     = dreq;
    d_uncached = 1'b0;
    d_refill   = 1'b0;
    d_invalid  = 1'b0;
    d_modified = 1'b0;
    case (seg_of(dreq.addr))
      SEG_KSEG0: begin
        t_dreq.addr = {1'b0, dreq.addr[30:0]};
        d_uncached  = k0_uncached;
      end
      SEG_KSEG1: begin
        t_dreq.addr = {3'b000, dreq.addr[28:0]};
        d_uncached  = 1'b1;
      end
      default: begin
        if (USE_TLB) begin
          if (d_hit) begin
            t_dreq.addr = {d_half.pfn, dreq.addr[11:0]};
            d_uncached  = (d_half.c == 3'd2);
          end
          d_refill   = dreq.valid & ~d_hit;
          d_invalid  = dreq.valid & d_hit & ~d_half.v;
          d_modified = dreq.valid & d_hit & d_half.v & ~d_half.d & (|dreq.strobe);
        end
      end
    endcase
    if (d_refill || d_invalid || d_modified) t_dreq.valid = 1'b0;
  end

  // Random stays within (wired, LAST]; it wraps to LAST instead of stepping down onto wired.
  assign wired_p1 = {1'b0, wired} + (IDX_W+1)'(1);

  always_comb begin
    random_next = random - IDX_W'(1);
    if (wired >= LAST || {1'b0, random} <= wired_p1) random_next = LAST;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entries[i] <= '0;
      random      <= LAST;
      tlb_rentry  <= '0;
      probe_done  <= 1'b0;
      probe_hit   <= 1'b0;
      probe_index <= '0;
    end else begin
      if (tlb_we) entries[tlb_wr_random ? random : tlb_windex] <= tlb_wentry;
      random     <= random_next;
      tlb_rentry <= entries[tlb_rindex];
      probe_done <= probe_req;
      if (probe_req) begin
        probe_hit   <= p_hit;
        probe_index <= p_hit ? p_idx : '0;
      end
    end
  end

endmodule

// File: tb/tb_tlb_mmu.sv
// Directed bench for tlb_mmu: segments, TLB lookup/exceptions, probe, random, legacy build.
module tb_tlb_mmu;
  import tlb_mmu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  dbus_req_t  dreq;
  ibus_req_t  t_ireq, l_t_ireq;
  dbus_req_t  t_dreq, l_t_dreq;
  logic       i_uncached, d_uncached, l_i_uncached, l_d_uncached;
  logic [7:0] asid;
  logic       k0_uncached;
  logic       i_refill, d_refill, i_invalid, d_invalid, d_modified;
  logic       l_i_refill, l_d_refill, l_i_invalid, l_d_invalid, l_d_modified;
  logic       tlb_we, tlb_wr_random;
  logic [3:0] tlb_windex, tlb_rindex, wired, random, l_random;
  tlb_entry_t tlb_wentry, tlb_rentry, l_tlb_rentry, e;
  logic       probe_req;
  logic [18:0] probe_vpn2;
  logic [7:0] probe_asid;
  logic       probe_done, probe_hit, l_probe_done, l_probe_hit;
  logic [3:0] probe_index, l_probe_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlb_mmu #(.TLB_ENTRIES(16), .USE_TLB(1'b1)) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .dreq(dreq), .t_ireq(t_ireq), .t_dreq(t_dreq),
    .i_uncached(i_uncached), .d_uncached(d_uncached), .asid(asid), .k0_uncached(k0_uncached),
    .i_refill(i_refill), .d_refill(d_refill), .i_invalid(i_invalid), .d_invalid(d_invalid),
    .d_modified(d_modified), .tlb_we(tlb_we), .tlb_wr_random(tlb_wr_random),
    .tlb_windex(tlb_windex), .tlb_wentry(tlb_wentry), .tlb_rindex(tlb_rindex),
    .tlb_rentry(tlb_rentry), .wired(wired), .random(random), .probe_req(probe_req),
    .probe_vpn2(probe_vpn2), .probe_asid(probe_asid), .probe_done(probe_done),
    .probe_hit(probe_hit), .probe_index(probe_index)
  );

  tlb_mmu #(.TLB_ENTRIES(16), .USE_TLB(1'b0)) dut_legacy (
    .clk(clk), .reset(reset), .ireq(ireq), .dreq(dreq), .t_ireq(l_t_ireq), .t_dreq(l_t_dreq),
    .i_uncached(l_i_uncached), .d_uncached(l_d_uncached), .asid(asid), .k0_uncached(k0_uncached),
    .i_refill(l_i_refill), .d_refill(l_d_refill), .i_invalid(l_i_invalid), .d_invalid(l_d_invalid),
    .d_modified(l_d_modified), .tlb_we(tlb_we), .tlb_wr_random(tlb_wr_random),
    .tlb_windex(tlb_windex), .tlb_wentry(tlb_wentry), .tlb_rindex(tlb_rindex),
    .tlb_rentry(l_tlb_rentry), .wired(wired), .random(l_random), .probe_req(probe_req),
    .probe_vpn2(probe_vpn2), .probe_asid(probe_asid), .probe_done(l_probe_done),
    .probe_hit(l_probe_hit), .probe_index(l_probe_index)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ireq = '0; dreq = '0; asid = 8'd0; k0_uncached = 1'b0;
    tlb_we = 1'b0; tlb_wr_random = 1'b0; tlb_windex = '0; tlb_wentry = '0;
    tlb_rindex = 4'd3; wired = 4'd4; probe_req = 1'b0; probe_vpn2 = '0; probe_asid = '0;

    tick(); tick();
    check("reset_random", random, 15);
    check("reset_rentry", tlb_rentry, 0);
    check("reset_probe_done", probe_done, 0);
    check("reset_probe_hit", probe_hit, 0);
    check("reset_probe_index", probe_index, 0);

    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("random_step%0d", k), random, (k <= 10) ? 15 - k : 15);
    end

    // Unmapped segments
    dreq.valid = 1'b1; dreq.addr = 32'hBFC0_0000;
    ireq.valid = 1'b1; ireq.addr = 32'h8000_1000;
    #1;
    check("kseg1_addr", t_dreq.addr, 32'h1FC0_0000);
    check("kseg1_uncached", d_uncached, 1);
    check("kseg1_no_refill", d_refill, 0);
    check("kseg0_addr", t_ireq.addr, 32'h0000_1000);
    check("kseg0_cached", i_uncached, 0);
    k0_uncached = 1'b1; #1;
    check("kseg0_k0_uncached", i_uncached, 1);
    k0_uncached = 1'b0;

    // Write index 3, same-cycle lookup still misses
    e = '0; e.vpn2 = 19'h00010; e.asid = 8'd5;
    e.p1.pfn = 20'h12345; e.p1.v = 1'b1; e.p1.c = 3'd3;
    tlb_wentry = e; tlb_windex = 4'd3; tlb_we = 1'b1;
    asid = 8'd5; dreq.addr = 32'h0002_1ABC; dreq.strobe = 4'h0;
    #1;
    check("write_cycle_refill", d_refill, 1);
    check("write_cycle_valid", t_dreq.valid, 0);
    tick(); tlb_we = 1'b0; #1;
    check("hit_addr", t_dreq.addr, 32'h1234_5ABC);
    check("hit_cached", d_uncached, 0);
    check("hit_no_refill", d_refill, 0);
    check("hit_valid", t_dreq.valid, 1);
    check("read_old_contents", tlb_rentry, 0);
    tick();
    check("read_new_vpn2", tlb_rentry.vpn2, 19'h00010);
    check("read_new_pfn1", tlb_rentry.p1.pfn, 20'h12345);

    // ASID mismatch, then global
    asid = 8'd6; #1;
    check("asid_refill", d_refill, 1);
    check("asid_valid", t_dreq.valid, 0);
    e.g = 1'b1; tlb_wentry = e; tlb_we = 1'b1;
    tick(); tlb_we = 1'b0; #1;
    check("global_no_refill", d_refill, 0);
    check("global_valid", t_dreq.valid, 1);
    check("global_addr", t_dreq.addr, 32'h1234_5ABC);

    // Even half of that page has v=0
    ireq.addr = 32'h0002_0ABC; #1;
    check("invalid_flag", i_invalid, 1);
    check("invalid_valid", t_ireq.valid, 0);
    check("invalid_no_refill", i_refill, 0);

    // Store to clean page
    dreq.strobe = 4'hF; #1;
    check("modified_flag", d_modified, 1);
    check("modified_valid", t_dreq.valid, 0);
    dreq.strobe = 4'h0; #1;
    check("load_no_modified", d_modified, 0);
    check("load_valid", t_dreq.valid, 1);

    // kseg2 entry at index 7, uncached (c=2)
    e = '0; e.vpn2 = 19'h60000; e.g = 1'b1;
    e.p0.pfn = 20'h00ABC; e.p0.c = 3'd2; e.p0.v = 1'b1; e.p0.d = 1'b1;
    tlb_wentry = e; tlb_windex = 4'd7; tlb_we = 1'b1;
    tick(); tlb_we = 1'b0;
    probe_req = 1'b1; probe_vpn2 = 19'h60000; probe_asid = 8'd0;
    dreq.addr = 32'hC000_0123; dreq.strobe = 4'hF; #1;
    check("kseg2_addr", t_dreq.addr, 32'h00AB_C123);
    check("kseg2_uncached", d_uncached, 1);
    check("kseg2_store_ok", d_modified, 0);
    tick();
    check("probe_done", probe_done, 1);
    check("probe_hit", probe_hit, 1);
    check("probe_index7", probe_index, 7);

    // Lower index duplicate; probe in the write cycle sees old contents
    e.p0.pfn = 20'h00DEF; e.p0.c = 3'd3;
    tlb_wentry = e; tlb_windex = 4'd2; tlb_we = 1'b1;
    tick(); tlb_we = 1'b0;
    check("probe_b2b_done", probe_done, 1);
    check("probe_old_index", probe_index, 7);
    tick();
    check("probe_lowest_index", probe_index, 2);
    check("multi_hit_addr", t_dreq.addr, 32'h00DE_F123);
    check("multi_hit_cached", d_uncached, 0);
    probe_vpn2 = 19'h12345;
    tick();
    check("probe_miss_done", probe_done, 1);
    check("probe_miss_hit", probe_hit, 0);
    probe_req = 1'b0;
    tick();
    check("probe_done_drops", probe_done, 0);

    // Legacy build: mapped passes through identity
    ireq.addr = 32'h0040_0000; #1;
    check("legacy_iaddr", l_t_ireq.addr, 32'h0040_0000);
    check("legacy_irefill", l_i_refill, 0);
    check("legacy_icached", l_i_uncached, 0);
    check("legacy_daddr", l_t_dreq.addr, 32'hC000_0123);
    check("legacy_drefill", l_d_refill, 0);
    check("tlb_irefill", i_refill, 1);

    // Reset mid-run drops a same-cycle write and probe
    e = '0; e.vpn2 = 19'h00010; e.g = 1'b1; e.p1.v = 1'b1; e.p1.d = 1'b1;
    tlb_wentry = e; tlb_windex = 4'd3; tlb_we = 1'b1; probe_req = 1'b1;
    reset = 1'b1;
    tick();
    check("rst_random", random, 15);
    check("rst_probe_done", probe_done, 0);
    reset = 1'b0; tlb_we = 1'b0; probe_req = 1'b0;
    dreq.addr = 32'h0002_1ABC; dreq.strobe = 4'h0;
    tick();
    check("rst_no_late_done", probe_done, 0);
    check("rst_rentry", tlb_rentry, 0);
    check("rst_entries_cleared", d_refill, 1);
    check("rst_random_next", random, 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
